// File: rtl/lift_cmd_fifo_writer.sv
// Write-side producer for the lift command FIFO: packs valid/ready commands into
// 12-bit words, buffers them in a small queue and injects a priority ESTOP word.
module lift_cmd_fifo_writer #(
    parameter int unsigned DATASIZE = 12,
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned CNTW     = 16
) (
    input  logic                      write_clk,
    input  logic                      read_reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [3:0]                cmd_floor,
    input  logic [5:0]                cmd_slot,
    input  logic                      estop,
    input  logic                      write_full,
    output logic                      write_enable,
    output logic [DATASIZE-1:0]       write_data,
    output logic [$clog2(QDEPTH):0]   queue_level,
    output logic [CNTW-1:0]           word_count,
    output logic                      illegal_op,
    output logic                      busy
);

    localparam int unsigned AW = $clog2(QDEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [DATASIZE-1:0] ESTOP_WORD = '1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ESTOP} state_t;

    state_t                state, state_nxt;
    logic                  busy_d;
    logic                  estop_q, estop_rise, estop_go;
    logic                  accept, cmd_legal, acc_legal;
    logic                  xfer, q_empty, pop, push, bypass;
    logic [DATASIZE-1:0]   cmd_word;
    logic                  hold_valid, hold_valid_d;
    logic [DATASIZE-1:0]   hold_data, hold_data_d;
    logic [LW-1:0]         level_d;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [DATASIZE-1:0]   mem [QDEPTH];

    // Handshake and transfer qualifiers
    assign estop_rise = estop & ~estop_q;
    assign estop_go   = estop_rise & (state != S_ESTOP);
    assign cmd_ready  = (state != S_ESTOP) & (queue_level < LW'(QDEPTH)) & ~estop_rise;
    assign accept     = cmd_valid & cmd_ready;
    assign cmd_legal  = (cmd_op != 2'b11);
    assign acc_legal  = accept & cmd_legal;
    assign cmd_word   = DATASIZE'({cmd_op, cmd_floor, cmd_slot});
    assign xfer       = hold_valid & ~write_full;
    assign q_empty    = (queue_level == '0);
    assign pop        = xfer & ~q_empty & ~estop_go;
    assign bypass     = acc_legal & q_empty & (~hold_valid | xfer);
    assign push       = acc_legal & ~bypass;

    assign write_enable = hold_valid;
    assign write_data   = hold_data;

    // Holding register and queue occupancy next values
    always_comb begin
        hold_valid_d = hold_valid;
        hold_data_d  = hold_data;
        level_d      = queue_level;
        if (estop_go) begin
            hold_valid_d = 1'b1;
            hold_data_d  = ESTOP_WORD;
        end else if (xfer) begin
            if (!q_empty) begin
                hold_data_d = mem[rd_ptr];
            end else if (bypass) begin
                hold_data_d = cmd_word;
            end else begin
                hold_valid_d = 1'b0;
            end
        end else if (bypass) begin
            hold_valid_d = 1'b1;
            hold_data_d  = cmd_word;
        end
        if (estop_go) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = queue_level + LW'(1);
        end else if (pop && !push) begin
            level_d = queue_level - LW'(1);
        end
    end

    always_ff @(posedge write_clk or negedge read_reset_n) begin
        if (!read_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (estop_go)       state_nxt = S_ESTOP;
                else if (acc_legal) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (estop_go)                            state_nxt = S_ESTOP;
                else if (!hold_valid_d && level_d == '0) state_nxt = S_IDLE;
            end
            S_ESTOP: begin
                if (xfer) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_nxt != S_IDLE);
    end

    always_ff @(posedge write_clk or negedge read_reset_n) begin
        if (!read_reset_n) begin
            estop_q     <= 1'b0;
            hold_valid  <= 1'b0;
            hold_data   <= '0;
            queue_level <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            word_count  <= '0;
            illegal_op  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            estop_q     <= estop;
            hold_valid  <= hold_valid_d;
            hold_data   <= hold_data_d;
            queue_level <= level_d;
            busy        <= busy_d;
            word_count  <= word_count + CNTW'(xfer);
            if (accept && !cmd_legal) illegal_op <= 1'b1;
            if (estop_go) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Queue storage carries no reset; occupancy is tracked by queue_level
    always_ff @(posedge write_clk) begin
        if (push) mem[wr_ptr] <= cmd_word;
    end

endmodule

// File: tb/tb_lift_cmd_fifo_writer.sv
// Scoreboard bench for lift_cmd_fifo_writer: driver pushes expected words,
// a negedge monitor pops and compares on every FIFO write.
module tb_lift_cmd_fifo_writer;

    localparam int unsigned CNTW = 4;

    logic              write_clk = 1'b0;
    logic              read_reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [3:0]        cmd_floor;
    logic [5:0]        cmd_slot;
    logic              estop;
    logic              write_full;
    logic              write_enable;
    logic [11:0]       write_data;
    logic [2:0]        queue_level;
    logic [CNTW-1:0]   word_count;
    logic              illegal_op;
    logic              busy;

    always #5 write_clk = ~write_clk;

    lift_cmd_fifo_writer #(.DATASIZE(12), .QDEPTH(4), .CNTW(CNTW)) dut (
        .write_clk    (write_clk),
        .read_reset_n (read_reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_floor    (cmd_floor),
        .cmd_slot     (cmd_slot),
        .estop        (estop),
        .write_full   (write_full),
        .write_enable (write_enable),
        .write_data   (write_data),
        .queue_level  (queue_level),
        .word_count   (word_count),
        .illegal_op   (illegal_op),
        .busy         (busy)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          model_cnt = 0;
    logic [11:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: a write completes at the next posedge when enable & ~full here
    always @(negedge write_clk) begin
        if (read_reset_n === 1'b1 && write_enable === 1'b1 && write_full === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(write_data), 32'h1000);
            end else begin
                chk("write_data", 32'(write_data), 32'(exp_q.pop_front()));
                model_cnt = (model_cnt + 1) % 16;
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [3:0] fl, input logic [5:0] sl,
                        input int max_cyc, output bit acc);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_floor = fl;
        cmd_slot  = sl;
        acc = 1'b0;
        for (int i = 0; i < max_cyc && !acc; i++) begin
            @(negedge write_clk);
            if (cmd_ready) acc = 1'b1;
            @(posedge write_clk);
            #1;
        end
        cmd_valid = 1'b0;
        if (acc && op != 2'b11) exp_q.push_back({op, fl, sl});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !write_enable) break;
            @(posedge write_clk);
            #1;
        end
        chk(name, 32'(exp_q.size()) + 32'(write_enable), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_we"},    32'(write_enable), 32'd0);
        chk({name, "_wd"},    32'(write_data),   32'd0);
        chk({name, "_level"}, 32'(queue_level),  32'd0);
        chk({name, "_count"}, 32'(word_count),   32'd0);
        chk({name, "_ill"},   32'(illegal_op),   32'd0);
        chk({name, "_busy"},  32'(busy),         32'd0);
    endtask

    bit acc;

    initial begin
        read_reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_floor = '0; cmd_slot = '0;
        estop = 1'b0; write_full = 1'b0;
        repeat (2) @(posedge write_clk);
        #1 read_reset_n = 1'b1;
        #1;
        chk_reset_outputs("reset");
        chk("reset_ready", 32'(cmd_ready), 32'd1);

        // Single command: latency one cycle, one write cycle, back to idle
        send(2'b01, 4'd3, 6'd5, 10, acc);
        chk("t1_acc", 32'(acc), 32'd1);
        chk("t1_we", 32'(write_enable), 32'd1);
        chk("t1_wd", 32'(write_data), 32'h4C5);
        chk("t1_busy", 32'(busy), 32'd1);
        @(posedge write_clk); #1;
        chk("t1_we_off", 32'(write_enable), 32'd0);
        chk("t1_count", 32'(word_count), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);

        // Six back-to-back commands at full throughput
        for (int i = 0; i < 6; i++) begin
            send(2'b10, 4'(i + 1), 6'(i * 7), 10, acc);
            chk("t2_acc", 32'(acc), 32'd1);
            chk("t2_we", 32'(write_enable), 32'd1);
            chk("t2_level_le1", 32'(queue_level <= 3'd1), 32'd1);
        end
        drain("t2_drain");
        chk("t2_count", 32'(word_count), 32'd7);

        // Stall: holding register plus four queued, sixth refused
        write_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(2'b00, 4'(9 - i), 6'(40 + i), 10, acc);
            chk("t3_acc", 32'(acc), 32'd1);
        end
        send(2'b01, 4'd1, 6'd1, 3, acc);
        chk("t3_refused", 32'(acc), 32'd0);
        chk("t3_ready", 32'(cmd_ready), 32'd0);
        chk("t3_level", 32'(queue_level), 32'd4);
        chk("t3_stable", 32'(write_data), 32'({2'b00, 4'd9, 6'd40}));
        write_full = 1'b0;
        drain("t3_drain");
        chk("t3_count", 32'(word_count), 32'd12);

        // Emergency stop with a stalled holding register and three queued
        write_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(2'b10, 4'(i), 6'(i + 20), 10, acc);
        end
        chk("t4_level", 32'(queue_level), 32'd3);
        estop = 1'b1;
        @(negedge write_clk);
        chk("t4_ready_rise", 32'(cmd_ready), 32'd0);
        @(posedge write_clk); #1;
        exp_q.delete();
        exp_q.push_back(12'hFFF);
        estop = 1'b0;
        chk("t4_level_clr", 32'(queue_level), 32'd0);
        chk("t4_wd", 32'(write_data), 32'hFFF);
        chk("t4_we", 32'(write_enable), 32'd1);
        chk("t4_busy", 32'(busy), 32'd1);
        repeat (3) @(posedge write_clk);
        #1;
        chk("t4_ready_hold", 32'(cmd_ready), 32'd0);
        chk("t4_wd_hold", 32'(write_data), 32'hFFF);
        write_full = 1'b0;
        @(posedge write_clk); #1;
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_ready_back", 32'(cmd_ready), 32'd1);
        chk("t4_count", 32'(word_count), 32'(model_cnt));

        // Illegal opcode: accepted, dropped, sticky flag
        send(2'b11, 4'd2, 6'd2, 10, acc);
        chk("t5_acc", 32'(acc), 32'd1);
        chk("t5_ill", 32'(illegal_op), 32'd1);
        repeat (3) @(posedge write_clk);
        #1;
        chk("t5_no_write", 32'(write_enable), 32'd0);
        chk("t5_ill_held", 32'(illegal_op), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);

        // Counter wrap: 17 transfers into a 4-bit counter
        read_reset_n = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #2;
        chk("t6_ill_cleared", 32'(illegal_op), 32'd0);
        @(posedge write_clk); #1;
        read_reset_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send(2'(i % 3), 4'(i), 6'(63 - i), 10, acc);
        end
        drain("t6_drain");
        chk("t6_wrap", 32'(word_count), 32'd1);

        // Asynchronous reset mid-burst
        write_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(2'b01, 4'(i + 5), 6'(i), 10, acc);
        end
        #2;
        read_reset_n = 1'b0;
        #1;
        exp_q.delete();
        model_cnt = 0;
        chk_reset_outputs("t7_rst");
        write_full = 1'b0;

        // estop held high across reset release yields one ESTOP word
        estop = 1'b1;
        @(posedge write_clk); #1;
        read_reset_n = 1'b1;
        @(posedge write_clk); #1;
        exp_q.push_back(12'hFFF);
        chk("t8_wd", 32'(write_data), 32'hFFF);
        chk("t8_we", 32'(write_enable), 32'd1);
        chk("t8_ready", 32'(cmd_ready), 32'd0);
        drain("t8_drain");
        chk("t8_count", 32'(word_count), 32'd1);
        repeat (3) @(posedge write_clk);
        #1;
        chk("t8_single", 32'(word_count), 32'd1);
        estop = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
